uvmt_cv32e40x_ibus_err_injector: RTL and testbench
==================================================

Name: uvmt_cv32e40x_ibus_err_injector

Overview:
Testbench-side OBI instruction-bus responder that sits between the core's instruction OBI port and the TB instruction memory. It generates the exception sources that the exceptions checker classifies. On programmed fetch addresses it injects either a bus error (err=1) or an illegal instruction word. Supports pipelined outstanding fetches, configurable response latency, and a one-shot/N-shot arming counter.

Parameters:
DEPTH, 4, max outstanding granted-but-unresponded fetches (power of 2, >=2)
LATENCY, 0, extra cycles a FIFO-head entry waits before rvalid (0..15)
ADDR_W, 32, OBI address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
obi_req_i  in  1  core fetch request
obi_gnt_o  out  1  grant
obi_addr_i  in  ADDR_W  fetch address
obi_rvalid_o  out  1  response valid
obi_rdata_o  out  32  response data
obi_err_o  out  1  response bus error
mem_addr_o  out  ADDR_W  address to TB memory (head entry)
mem_rdata_i  in  32  combinational memory read data
inj_arm_i  in  1  pulse: load injection config
inj_addr_i  in  ADDR_W  target fetch address (word-aligned compare)
inj_kind_i  in  1  0=bus error, 1=illegal instruction
inj_count_i  in  8  number of injections to perform (0 = disarm)
inj_busy_o  out  1  remaining count nonzero
inj_done_cnt_o  out  16  total injections delivered, saturating

Behaviour:
- Reset (synchronous, rst_ni low at clk_i edge): FIFO emptied, outstanding fetches dropped, FSM->IDLE, remaining=0, done count=0. All outputs low/zero except mem_addr_o, which follows the head pointer (0).
- gnt: obi_gnt_o = obi_req_i && !full. Purely combinational; no grant while full even if popping this cycle.
- Grant cycle: push entry {addr, inj, kind}. inj=1 iff remaining!=0 and obi_addr_i[ADDR_W-1:2]==inj_addr_q[ADDR_W-1:2]; if so, remaining decrements by 1 this cycle.
- Arm: inj_arm_i loads inj_addr_q, inj_kind_q, remaining=inj_count_i and overrides any current arming. If an arm coincides with a matching grant, the grant is evaluated against the pre-arm registers, the new config wins, and the grant's decrement is discarded.
- inj_busy_o = (remaining!=0), registered.
- Response FSM:
  - IDLE: FIFO empty. On non-empty, go to WAIT with cnt=LATENCY, or directly to RESP if LATENCY==0.
  - WAIT: cnt decrements; at 0 go to RESP.
  - RESP: rvalid=1 for exactly one cycle; head is popped. If the FIFO still holds entries, go to RESP when LATENCY==0, else to WAIT with cnt=LATENCY. If empty, go to IDLE.
- Minimum latency: rvalid is asserted no earlier than 1 cycle after the entry's grant. A push into an empty FIFO is seen by the FSM the next cycle. Back-to-back rvalid is allowed when LATENCY=0.
- Response data in RESP:
  - head.inj=0: rdata=mem_rdata_i, err=0.
  - inj with kind=0: rdata=0, err=1.
  - inj with kind=1: rdata=ILLEGAL_INSN, err=0.
- Responses are returned in grant order. rdata and err are 0 whenever rvalid=0.
- inj_done_cnt_o increments on each RESP with head.inj=1 and saturates at 16'hFFFF.
- Simultaneous push and pop: legal when not full; occupancy is unchanged.

Optional Feature:
UVMT_IBUS_ERR_INJ_STALL_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle. obi_gnt_o is additionally masked when lfsr[1:0]==2'b00, giving ~25% grant stalls. The OBI rule holds: obi_addr_i must stay stable while obi_req_i is high and gnt is low.
- Undefined: no LFSR, and grant depends only on req and full.

Decomposition:
- Package uvmt_cv32e40x_ibus_inj_pkg holds:
  - inj_kind_e enum (INJ_BUSERR=0, INJ_ILLEGAL=1)
  - fifo entry struct {addr, inj, kind}
  - localparam ILLEGAL_INSN=32'h0000_0000
- Sub-module uvmt_cv32e40x_ibus_inj_fifo: synchronous FIFO of entry structs, DEPTH-parameterised, with full/empty flags and a wrap-around pointer plus extra MSB.

Test Plan:
- Not armed; fetches 0x80, 0x84, 0x88 with LATENCY=0 and req held -> gnt on 3 consecutive cycles, rvalid on 3 consecutive cycles starting 1 cycle after the first gnt, rdata=mem contents, err=0.
- Arm addr=0x84, kind=0, count=1; fetch 0x80, 0x84, 0x84 -> second response err=1 and rdata=0; third response normal; inj_busy_o drops after the 0x84 grant; inj_done_cnt_o=1.
- Arm addr=0x86 (unaligned), kind=1, count=2; fetch 0x84 twice -> both responses rdata=0x00000000, err=0, done count=2; a third fetch is normal.
- DEPTH=4, LATENCY=3, req held for 8 cycles -> gnt drops after 4 grants; first rvalid 4 cycles after the first gnt; no entry is lost and responses stay in order.
- Arm in the same cycle as a matching grant with the old config disarmed -> that fetch is not injected; the next matching fetch is injected.
- Assert rst_ni low while 3 entries are outstanding -> next cycle rvalid=0 and gnt follows req; done count=0 and busy=0.

Source files
------------

// File: rtl/uvmt_cv32e40x_ibus_inj_pkg.sv
// Shared types for the instruction-bus error injector.
//   inj_kind_e    : what to inject on a matching fetch (bus error or illegal instruction word)
//   ibus_entry_t  : one granted-but-unanswered fetch {addr, inj, kind}
//   ILLEGAL_INSN  : word returned for an illegal-instruction injection
// Entry addresses are stored at IBUS_ADDR_W_MAX bits; the top truncates to its own ADDR_W.
package uvmt_cv32e40x_ibus_inj_pkg;

  typedef enum logic {
    INJ_BUSERR  = 1'b0,
    INJ_ILLEGAL = 1'b1
  } inj_kind_e;

  localparam int unsigned IBUS_ADDR_W_MAX = 64;

  localparam logic [31:0] ILLEGAL_INSN = 32'h0000_0000;

  typedef struct packed {
    logic [IBUS_ADDR_W_MAX-1:0] addr;
    logic                       inj;
    inj_kind_e                  kind;
  } ibus_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } resp_state_e;

endpackage

// File: rtl/uvmt_cv32e40x_ibus_inj_fifo.sv
// Synchronous FIFO of outstanding fetch entries.
// Pointers carry one extra MSB so full and empty are distinguished without a separate counter.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i/wdata_i: write an entry (ignored while full)
//   pop_i         : drop the head entry (ignored while empty)
//   head_o        : current head entry
//   full_o/empty_o: occupancy flags
//   count_o       : current occupancy
module uvmt_cv32e40x_ibus_inj_fifo
  import uvmt_cv32e40x_ibus_inj_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  ibus_entry_t   wdata_i,
  input  logic          pop_i,
  output ibus_entry_t   head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [PtrW:0] count_o
);

  ibus_entry_t   storage_q [DEPTH];
  logic [PtrW:0] wr_ptr_q;
  logic [PtrW:0] rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = storage_q[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        storage_q[i] <= '0;
      end
    end else begin
      if (push_i && !full_o) begin
        storage_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
        wr_ptr_q                      <= wr_ptr_q + 1'b1;
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uvmt_cv32e40x_ibus_err_injector.sv
// OBI instruction-bus responder that injects bus errors or illegal instruction words on
// programmed fetch addresses. Fetches are queued in grant order and answered after LATENCY
// extra cycles; the injection is armed for inj_count_i matching fetches.
// Optional: define UVMT_IBUS_ERR_INJ_STALL_EN to add pseudo-random grant stalls (16-bit LFSR).
// Ports:
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   obi_req_i/obi_gnt_o    : fetch request / grant
//   obi_addr_i             : fetch address
//   obi_rvalid_o/rdata/err : response channel (rdata/err zero while rvalid is low)
//   mem_addr_o/mem_rdata_i : head-entry address to TB memory and its combinational data
//   inj_arm_i..inj_count_i : injection configuration load
//   inj_busy_o             : injections still pending
//   inj_done_cnt_o         : injected responses delivered, saturating
module uvmt_cv32e40x_ibus_err_injector
  import uvmt_cv32e40x_ibus_inj_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 0,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              obi_req_i,
  output logic              obi_gnt_o,
  input  logic [ADDR_W-1:0] obi_addr_i,
  output logic              obi_rvalid_o,
  output logic [31:0]       obi_rdata_o,
  output logic              obi_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              inj_arm_i,
  input  logic [ADDR_W-1:0] inj_addr_i,
  input  logic              inj_kind_i,
  input  logic [7:0]        inj_count_i,
  output logic              inj_busy_o,
  output logic [15:0]       inj_done_cnt_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] OneEntry = {{PtrW{1'b0}}, 1'b1};
  localparam logic [3:0] LatLoad = 4'(LATENCY);

  ibus_entry_t   push_entry;
  ibus_entry_t   head;
  logic          full;
  logic          empty;
  logic [PtrW:0] count;
  logic          push;
  logic          pop;
  logic          stall;
  logic          match;

  resp_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-3:0] inj_addr_q, inj_addr_d;
  inj_kind_e         inj_kind_q, inj_kind_d;
  logic [7:0]        remaining_q, remaining_d;
  logic [15:0]       done_q, done_d;

`ifdef UVMT_IBUS_ERR_INJ_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11.
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign stall  = (lfsr_q[1:0] == 2'b00);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign stall = 1'b0;
`endif

  // No grant while full, even if the head pops this cycle.
  assign obi_gnt_o = obi_req_i && !full && !stall;
  assign push      = obi_gnt_o;

  // Word-granular compare against the pre-arm configuration.
  assign match = (remaining_q != 8'd0) && (obi_addr_i[ADDR_W-1:2] == inj_addr_q);

  always_comb begin
    push_entry      = '0;
    push_entry.addr = IBUS_ADDR_W_MAX'(obi_addr_i);
    push_entry.inj  = match;
    push_entry.kind = inj_kind_q;
  end

  uvmt_cv32e40x_ibus_inj_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // A new arm overrides everything, including a decrement from a coincident matching grant.
  always_comb begin
    inj_addr_d  = inj_addr_q;
    inj_kind_d  = inj_kind_q;
    remaining_d = remaining_q;
    if (inj_arm_i) begin
      inj_addr_d  = inj_addr_i[ADDR_W-1:2];
      inj_kind_d  = inj_kind_e'(inj_kind_i);
      remaining_d = inj_count_i;
    end else if (push && match) begin
      remaining_d = remaining_q - 8'd1;
    end
  end

  // Response FSM. The push term lets a grant into an empty FIFO leave IDLE at the same edge,
  // so the earliest response is one cycle after the grant.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pop          = 1'b0;
    obi_rvalid_o = 1'b0;
    obi_rdata_o  = '0;
    obi_err_o    = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty || push) begin
          if (LATENCY == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = LatLoad;
          end
        end
      end
      StWait: begin
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        pop          = 1'b1;
        obi_rvalid_o = 1'b1;
        if (!head.inj) begin
          obi_rdata_o = mem_rdata_i;
        end else if (head.kind == INJ_BUSERR) begin
          obi_err_o = 1'b1;
        end else begin
          obi_rdata_o = ILLEGAL_INSN;
        end
        if ((count != OneEntry) || push) begin
          if (LATENCY == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = LatLoad;
          end
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    done_d = done_q;
    if ((state_q == StResp) && head.inj && (done_q != 16'hFFFF)) begin
      done_d = done_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      inj_addr_q  <= '0;
      inj_kind_q  <= INJ_BUSERR;
      remaining_q <= '0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inj_addr_q  <= inj_addr_d;
      inj_kind_q  <= inj_kind_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  assign inj_busy_o     = (remaining_q != 8'd0);
  assign inj_done_cnt_o = done_q;
  assign mem_addr_o     = head.addr[ADDR_W-1:0];

  // Byte-offset bits of the arm address and the widened entry address are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{inj_addr_i[1:0], head.addr};

endmodule

// File: tb/tb_uvmt_cv32e40x_ibus_err_injector.sv
module tb_uvmt_cv32e40x_ibus_err_injector;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] ILLEGAL = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req, gnt, rvalid, err, arm, kind, busy;
  logic [31:0] addr [2];
  logic [31:0] rdata [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_rdata [2];
  logic [31:0] inj_addr [2];
  logic [7:0]  cnt [2];
  logic [15:0] done [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit model_on = 0;

  // Observed outputs of the most recent cycle.
  logic [1:0]  o_gnt, o_rvalid, o_err, o_busy;
  logic [31:0] o_rdata [2];
  logic [15:0] o_done [2];

  // Reference model: per instance, a ring of outstanding fetches with predicted response cycle.
  logic [31:0] m_addr [2][32];
  bit          m_inj [2][32];
  bit          m_kind [2][32];
  int          m_rt [2][32];
  int          m_head [2];
  int          m_tail [2];
  int          m_last_rt [2];
  int          m_rem [2];
  logic [31:0] m_inj_addr [2];
  bit          m_inj_kind [2];
  int          m_done [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return ((a * 32'h9E37_79B1) ^ 32'h1234_5678) | 32'h1;
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  assign mem_rdata[0] = mem_fn(mem_addr[0]);
  assign mem_rdata[1] = mem_fn(mem_addr[1]);

  uvmt_cv32e40x_ibus_err_injector #(.DEPTH(4), .LATENCY(0), .ADDR_W(32)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req[0]), .obi_gnt_o(gnt[0]), .obi_addr_i(addr[0]),
    .obi_rvalid_o(rvalid[0]), .obi_rdata_o(rdata[0]), .obi_err_o(err[0]),
    .mem_addr_o(mem_addr[0]), .mem_rdata_i(mem_rdata[0]), .inj_arm_i(arm[0]),
    .inj_addr_i(inj_addr[0]), .inj_kind_i(kind[0]), .inj_count_i(cnt[0]),
    .inj_busy_o(busy[0]), .inj_done_cnt_o(done[0])
  );

  uvmt_cv32e40x_ibus_err_injector #(.DEPTH(4), .LATENCY(3), .ADDR_W(32)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req[1]), .obi_gnt_o(gnt[1]), .obi_addr_i(addr[1]),
    .obi_rvalid_o(rvalid[1]), .obi_rdata_o(rdata[1]), .obi_err_o(err[1]),
    .mem_addr_o(mem_addr[1]), .mem_rdata_i(mem_rdata[1]), .inj_arm_i(arm[1]),
    .inj_addr_i(inj_addr[1]), .inj_kind_i(kind[1]), .inj_count_i(cnt[1]),
    .inj_busy_o(busy[1]), .inj_done_cnt_o(done[1])
  );

  task automatic model_reset(input int i);
    m_head[i] = 0; m_tail[i] = 0; m_last_rt[i] = -1000;
    m_rem[i] = 0; m_inj_addr[i] = '0; m_inj_kind[i] = 0; m_done[i] = 0;
  endtask

  task automatic set_idle();
    req = '0; arm = '0; kind = '0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; inj_addr[i] = '0; cnt[i] = '0;
    end
  endtask

  // One clock: sample at negedge, score against the model, advance the model, then step.
  task automatic cycle();
    @(negedge clk);
    o_gnt = gnt; o_rvalid = rvalid; o_err = err; o_busy = busy;
    for (int i = 0; i < 2; i++) begin
      o_rdata[i] = rdata[i]; o_done[i] = done[i];
    end
    if (model_on) begin
      for (int i = 0; i < 2; i++) begin
        int occ; int h; bit e_gnt; bit e_rv; logic [31:0] e_rdata; bit e_err; bit match;
        occ = m_tail[i] - m_head[i];
        h = m_head[i] % 32;
        e_gnt = req[i] && (occ < int'(DEPTH));
        e_rv = (occ > 0) && (m_rt[i][h] == cyc);
        e_rdata = '0; e_err = 0;
        if (e_rv) begin
          e_rdata = m_inj[i][h] ? ILLEGAL : mem_fn(m_addr[i][h]);
          if (m_inj[i][h] && !m_kind[i][h]) e_rdata = '0;
          e_err = m_inj[i][h] && !m_kind[i][h];
        end
        checks++; if (o_gnt[i] !== e_gnt) begin errors++;
          $display("FAIL model_gnt[%0d] cyc=%0d got=%b exp=%b", i, cyc, o_gnt[i], e_gnt); end
        checks++; if (o_rvalid[i] !== e_rv) begin errors++;
          $display("FAIL model_rvalid[%0d] cyc=%0d got=%b exp=%b", i, cyc, o_rvalid[i], e_rv); end
        checks++; if (o_rdata[i] !== e_rdata) begin errors++;
          $display("FAIL model_rdata[%0d] cyc=%0d got=%h exp=%h", i, cyc, o_rdata[i], e_rdata); end
        checks++; if (o_err[i] !== e_err) begin errors++;
          $display("FAIL model_err[%0d] cyc=%0d got=%b exp=%b", i, cyc, o_err[i], e_err); end
        checks++; if (o_busy[i] !== (m_rem[i] != 0)) begin errors++;
          $display("FAIL model_busy[%0d] cyc=%0d got=%b exp=%b", i, cyc, o_busy[i], m_rem[i] != 0); end
        checks++; if (o_done[i] !== 16'(m_done[i])) begin errors++;
          $display("FAIL model_done[%0d] cyc=%0d got=%0d exp=%0d", i, cyc, o_done[i], m_done[i]); end
        if (rst_n) begin
          if (e_rv) begin
            if (m_inj[i][h] && m_done[i] < 65535) m_done[i]++;
            m_head[i]++;
          end
          if (e_gnt) begin
            int t;
            t = m_tail[i] % 32;
            match = (m_rem[i] != 0) && (addr[i][31:2] == m_inj_addr[i][31:2]);
            m_addr[i][t] = addr[i];
            m_inj[i][t] = match;
            m_kind[i][t] = m_inj_kind[i];
            m_rt[i][t] = ((cyc > m_last_rt[i]) ? cyc : m_last_rt[i]) + lat(i) + 1;
            m_last_rt[i] = m_rt[i][t];
            m_tail[i]++;
            if (match) m_rem[i]--;
          end
          if (arm[i]) begin
            m_rem[i] = int'(cnt[i]); m_inj_addr[i] = inj_addr[i]; m_inj_kind[i] = kind[i];
          end
        end
      end
    end
    if (!rst_n) begin
      model_reset(0); model_reset(1); model_on = 1;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    cycle();
    for (int i = 0; i < 2; i++) begin
      checks++; if (o_rvalid[i] !== 1'b0 || o_gnt[i] !== 1'b0 || o_busy[i] !== 1'b0 ||
                    o_done[i] !== 16'd0 || o_rdata[i] !== 32'd0 || o_err[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs[%0d] got=rv%b g%b b%b d%0d r%h e%b exp=all zero", i,
                 o_rvalid[i], o_gnt[i], o_busy[i], o_done[i], o_rdata[i], o_err[i]);
      end
    end
  endtask

  task automatic test_no_inject();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req[0] = (k < 3); addr[0] = 32'h80 + 32'(4 * k);
      cycle();
      checks++; if (o_gnt[0] !== (k < 3)) begin errors++;
        $display("FAIL noinj_gnt k=%0d got=%b exp=%b", k, o_gnt[0], k < 3); end
      checks++; if (o_rvalid[0] !== (k >= 1 && k <= 3)) begin errors++;
        $display("FAIL noinj_rvalid k=%0d got=%b exp=%b", k, o_rvalid[0], k >= 1 && k <= 3); end
      if (k >= 1 && k <= 3) begin
        checks++;
        if (o_rdata[0] !== mem_fn(32'h80 + 32'(4 * (k - 1))) || o_err[0] !== 1'b0) begin
          errors++;
          $display("FAIL noinj_data k=%0d got=%h/%b exp=%h/0", k, o_rdata[0], o_err[0],
                   mem_fn(32'h80 + 32'(4 * (k - 1))));
        end
      end
    end
    set_idle();
  endtask

  task automatic test_buserr();
    logic [31:0] seq [3];
    seq[0] = 32'h80; seq[1] = 32'h84; seq[2] = 32'h84;
    do_reset();
    arm[0] = 1'b1; inj_addr[0] = 32'h84; kind[0] = 1'b0; cnt[0] = 8'd1;
    cycle();
    arm[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req[0] = (k < 3); addr[0] = (k < 3) ? seq[k] : 32'h0;
      cycle();
      if (k <= 1) begin
        checks++; if (o_busy[0] !== 1'b1) begin errors++;
          $display("FAIL buserr_busy_pre k=%0d got=%b exp=1", k, o_busy[0]); end
      end
      if (k == 2) begin
        checks++; if (o_busy[0] !== 1'b0) begin errors++;
          $display("FAIL buserr_busy_post got=%b exp=0", o_busy[0]); end
        checks++; if (o_rvalid[0] !== 1'b1 || o_err[0] !== 1'b1 || o_rdata[0] !== 32'h0) begin
          errors++;
          $display("FAIL buserr_resp got=rv%b e%b %h exp=rv1 e1 00000000",
                   o_rvalid[0], o_err[0], o_rdata[0]);
        end
      end
      if (k == 3) begin
        checks++; if (o_err[0] !== 1'b0 || o_rdata[0] !== mem_fn(32'h84)) begin errors++;
          $display("FAIL buserr_third got=%h/%b exp=%h/0", o_rdata[0], o_err[0], mem_fn(32'h84));
        end
        checks++; if (o_done[0] !== 16'd1) begin errors++;
          $display("FAIL buserr_done got=%0d exp=1", o_done[0]); end
      end
    end
    set_idle();
  endtask

  task automatic test_illegal();
    do_reset();
    arm[0] = 1'b1; inj_addr[0] = 32'h86; kind[0] = 1'b1; cnt[0] = 8'd2;
    cycle();
    arm[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req[0] = (k < 3); addr[0] = 32'h84;
      cycle();
      if (k == 1 || k == 2) begin
        checks++; if (o_rvalid[0] !== 1'b1 || o_rdata[0] !== ILLEGAL || o_err[0] !== 1'b0) begin
          errors++;
          $display("FAIL illegal_resp k=%0d got=rv%b %h e%b exp=rv1 %h e0", k, o_rvalid[0],
                   o_rdata[0], o_err[0], ILLEGAL);
        end
      end
      if (k == 2) begin
        checks++; if (o_busy[0] !== 1'b0) begin errors++;
          $display("FAIL illegal_busy got=%b exp=0", o_busy[0]); end
      end
      if (k == 3) begin
        checks++; if (o_rdata[0] !== mem_fn(32'h84) || o_err[0] !== 1'b0) begin errors++;
          $display("FAIL illegal_third got=%h/%b exp=%h/0", o_rdata[0], o_err[0], mem_fn(32'h84));
        end
        checks++; if (o_done[0] !== 16'd2) begin errors++;
          $display("FAIL illegal_done got=%0d exp=2", o_done[0]); end
      end
    end
    set_idle();
  endtask

  task automatic test_latency();
    logic [31:0] q [$];
    logic [31:0] next_addr;
    logic [31:0] exp_a;
    int ngnt; int nresp; int first_gnt; int first_rv; int t;
    do_reset();
    next_addr = 32'h100; ngnt = 0; nresp = 0; first_gnt = -1; first_rv = -1;
    for (t = 0; t < 80 && !(t >= 8 && q.size() == 0); t++) begin
      req[1] = (t < 8); addr[1] = next_addr;
      cycle();
      if (t == 4) begin
        checks++; if (o_gnt[1] !== 1'b0 || ngnt != 4) begin errors++;
          $display("FAIL lat_full_stall got=gnt%b after %0d grants exp=gnt0 after 4",
                   o_gnt[1], ngnt);
        end
      end
      if (o_gnt[1]) begin
        q.push_back(next_addr); next_addr += 32'h4; ngnt++;
        if (first_gnt < 0) first_gnt = t;
      end
      if (o_rvalid[1]) begin
        nresp++;
        if (first_rv < 0) first_rv = t;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL lat_extra_resp t=%0d got=rvalid exp=none", t);
        end else begin
          exp_a = q.pop_front();
          if (o_rdata[1] !== mem_fn(exp_a) || o_err[1] !== 1'b0) begin errors++;
            $display("FAIL lat_order t=%0d got=%h exp=%h", t, o_rdata[1], mem_fn(exp_a)); end
        end
      end
    end
    checks++; if (first_rv - first_gnt != 4) begin errors++;
      $display("FAIL lat_first_rvalid got=%0d exp=4", first_rv - first_gnt); end
    checks++; if (q.size() != 0 || nresp != ngnt) begin errors++;
      $display("FAIL lat_drain got=%0d resp of %0d grants exp=all", nresp, ngnt); end
    checks++; if (ngnt != 5) begin errors++;
      $display("FAIL lat_grants got=%0d exp=5", ngnt); end
    set_idle();
  endtask

  task automatic test_arm_collide();
    do_reset();
    // Disarmed old config: the coincident fetch is not injected.
    arm[0] = 1'b1; inj_addr[0] = 32'h90; kind[0] = 1'b0; cnt[0] = 8'd1;
    req[0] = 1'b1; addr[0] = 32'h90;
    cycle();
    arm[0] = 1'b0;
    cycle();
    checks++; if (o_err[0] !== 1'b0 || o_rdata[0] !== mem_fn(32'h90) || o_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL collide_first got=%h/e%b/b%b exp=%h/e0/b1", o_rdata[0], o_err[0], o_busy[0],
               mem_fn(32'h90));
    end
    req[0] = 1'b0;
    cycle();
    checks++; if (o_err[0] !== 1'b1 || o_rdata[0] !== 32'h0 || o_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL collide_second got=%h/e%b/b%b exp=0/e1/b0", o_rdata[0], o_err[0], o_busy[0]);
    end
    // Armed old config: old kind injects, new count survives.
    arm[0] = 1'b1; inj_addr[0] = 32'hA0; kind[0] = 1'b1; cnt[0] = 8'd1;
    cycle();
    kind[0] = 1'b0; req[0] = 1'b1; addr[0] = 32'hA0;
    cycle();
    arm[0] = 1'b0;
    cycle();
    checks++; if (o_rdata[0] !== ILLEGAL || o_err[0] !== 1'b0 || o_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL collide_old_kind got=%h/e%b/b%b exp=%h/e0/b1", o_rdata[0], o_err[0],
               o_busy[0], ILLEGAL);
    end
    req[0] = 1'b0;
    cycle();
    checks++; if (o_err[0] !== 1'b1 || o_busy[0] !== 1'b0 || o_done[0] !== 16'd2) begin
      errors++;
      $display("FAIL collide_new_kind got=e%b/b%b/d%0d exp=e1/b0/d2", o_err[0], o_busy[0],
               o_done[0]);
    end
    set_idle();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    arm[1] = 1'b1; inj_addr[1] = 32'h204; kind[1] = 1'b0; cnt[1] = 8'd5;
    cycle();
    arm[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[1] = 1'b1; addr[1] = 32'h200 + 32'(4 * k);
      cycle();
    end
    req[1] = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    req = 2'b11; addr[0] = 32'h400; addr[1] = 32'h404;
    cycle();
    for (int i = 0; i < 2; i++) begin
      checks++; if (o_rvalid[i] !== 1'b0 || o_gnt[i] !== 1'b1 || o_busy[i] !== 1'b0 ||
                    o_done[i] !== 16'd0) begin
        errors++;
        $display("FAIL midreset[%0d] got=rv%b g%b b%b d%0d exp=rv0 g1 b0 d0", i, o_rvalid[i],
                 o_gnt[i], o_busy[i], o_done[i]);
      end
    end
    req = 2'b00;
    for (int k = 0; k < 8; k++) cycle();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 2; i++) begin
        req[i] = ($urandom_range(0, 99) < 70);
        addr[i] = 32'h80 + 32'($urandom_range(0, 31));
        arm[i] = ($urandom_range(0, 99) < 6);
        inj_addr[i] = 32'h80 + 32'($urandom_range(0, 31));
        kind[i] = 1'($urandom_range(0, 1));
        cnt[i] = 8'($urandom_range(0, 3));
      end
      cycle();
    end
    set_idle();
    for (int k = 0; k < 20; k++) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_idle();
    test_reset();
    test_no_inject();
    test_buserr();
    test_illegal();
    test_latency();
    test_arm_collide();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
